// File: rtl/inv_sub_bytes_serial.sv
// Inverse SubBytes for AES-128 decryption. LANES shared inverse S-boxes walk the
// 16 state bytes over 16/LANES cycles; the result is published in one step at the end.

module inv_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  // Entry i sits at bits [2047-8i -: 8]: row-major copy of the inverse S-box table.
  localparam logic [2047:0] TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };
  logic [10:0] idx;
  assign idx  = 11'd2047 - {din, 3'b000};
  assign dout = TBL[idx -: 8];
endmodule

module inv_sub_bytes_serial #(
  parameter int LANES = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [127:0] bytes,
  input  logic         enable,
  output logic [127:0] inv_sub_bytes,
  output logic         done_flag,
  output logic         busy
);
  localparam int N  = 16 / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [15:0][7:0]       work_q, work_d;
  logic [127:0]           out_q, out_d;
  logic                   done_q, done_d;
  logic [LANES-1:0][3:0]  lane_idx;
  logic [LANES-1:0][7:0]  lane_in, lane_out;

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_idx[l] = 4'(int'(cnt_q) * LANES + l);
      lane_in[l]  = work_q[lane_idx[l]];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    inv_sbox u_sbox (.din(lane_in[l]), .dout(lane_out[l]));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    out_d   = out_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (enable) begin
        work_d  = bytes;
        cnt_d   = '0;
        state_d = BUSY;
      end
      BUSY: begin
        for (int l = 0; l < LANES; l++) work_d[lane_idx[l]] = lane_out[l];
        if (cnt_q == CW'(N - 1)) begin
          // Publish including this cycle's lanes so no partial state is ever exposed.
          out_d   = work_d;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign inv_sub_bytes = out_q;
  assign done_flag     = done_q;
  assign busy          = (state_q == BUSY);
endmodule

// File: tb/tb_inv_sub_bytes_serial.sv
// Bench for inv_sub_bytes_serial: LANES=4,1,16 instances share stimulus and are checked
// against a GF(2^8)-derived S-box model plus transaction-level timing expectations.

module tb_inv_sub_bytes_serial;
  logic         CLK = 1'b0;
  logic         RST;
  logic [127:0] bytes;
  logic         enable;
  logic [127:0] out_w [3];
  logic         done_w [3];
  logic         busy_w [3];

  int nn [3] = '{4, 16, 1};
  int vectors = 0;
  int errs = 0;
  logic [7:0]   sbox_t [256];
  logic [7:0]   isbox_t [256];
  logic [127:0] hist [64];

  localparam logic [127:0] V1   = 128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [127:0] V1_X = 128'h000102030405060708090a0b0c0d0e0f;

  always #5 CLK = ~CLK;

  inv_sub_bytes_serial #(.LANES(4)) u_l4 (
    .CLK(CLK), .RST(RST), .bytes(bytes), .enable(enable),
    .inv_sub_bytes(out_w[0]), .done_flag(done_w[0]), .busy(busy_w[0]));
  inv_sub_bytes_serial #(.LANES(1)) u_l1 (
    .CLK(CLK), .RST(RST), .bytes(bytes), .enable(enable),
    .inv_sub_bytes(out_w[1]), .done_flag(done_w[1]), .busy(busy_w[1]));
  inv_sub_bytes_serial #(.LANES(16)) u_l16 (
    .CLK(CLK), .RST(RST), .bytes(bytes), .enable(enable),
    .inv_sub_bytes(out_w[2]), .done_flag(done_w[2]), .busy(busy_w[2]));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] b2w(input logic b);
    return {127'b0, b};
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    for (int b = 1; b < 256; b++)
      if (gmul(a, 8'(b)) == 8'h01) return 8'(b);
    return 8'h00;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  // Forward S-box = affine(ginv(x)); the inverse table is its permutation inverse.
  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] g;
    g = ginv(x);
    return g ^ rotl(g, 1) ^ rotl(g, 2) ^ rotl(g, 3) ^ rotl(g, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] v);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = isbox_t[v[8*k +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One-cycle start pulse, then watch every instance for latency, busy length and result.
  task automatic run_block(input logic [127:0] v, input logic [127:0] exp, input string tag);
    logic [127:0] prev [3];
    logic [127:0] res [3];
    int done_at [3], nbusy [3], ndone [3];
    @(negedge CLK);
    prev = out_w;
    for (int d = 0; d < 3; d++) begin done_at[d] = -1; nbusy[d] = 0; ndone[d] = 0; res[d] = 'x; end
    bytes = v; enable = 1'b1;
    @(negedge CLK);
    enable = 1'b0;
    for (int t = 1; t <= 20; t++) begin
      for (int d = 0; d < 3; d++) begin
        if (busy_w[d]) begin
          nbusy[d]++;
          chk($sformatf("%s hold%0d", tag, d), out_w[d], prev[d]);
        end
        if (done_w[d]) begin ndone[d]++; done_at[d] = t; res[d] = out_w[d]; end
      end
      bytes = rnd128();
      @(negedge CLK);
    end
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s lat%0d", tag, d), 128'(done_at[d]), 128'(nn[d] + 1));
      chk($sformatf("%s busy%0d", tag, d), 128'(nbusy[d]), 128'(nn[d]));
      chk($sformatf("%s ndone%0d", tag, d), 128'(ndone[d]), 128'd1);
      chk($sformatf("%s out%0d", tag, d), res[d], exp);
    end
  endtask

  // enable held high for ncyc cycles with hist[t] on bytes; starts only every N+2 cycles.
  task automatic run_stream(input int ncyc, input string tag);
    int next_s [3], ndone [3], s;
    for (int d = 0; d < 3; d++) begin next_s[d] = 0; ndone[d] = 0; end
    @(negedge CLK);
    for (int t = 0; t < ncyc + 20; t++) begin
      for (int d = 0; d < 3; d++) if (done_w[d]) begin
        s = t - nn[d] - 1;
        chk($sformatf("%s start%0d", tag, d), 128'(s), 128'(next_s[d]));
        if (s >= 0 && s < 64) chk($sformatf("%s out%0d", tag, d), out_w[d], model(hist[s]));
        next_s[d] += nn[d] + 2;
        ndone[d]++;
      end
      if (t < ncyc) begin bytes = hist[t]; enable = 1'b1; end
      else begin bytes = rnd128(); enable = 1'b0; end
      @(negedge CLK);
    end
    for (int d = 0; d < 3; d++)
      chk($sformatf("%s count%0d", tag, d), 128'(ndone[d]), 128'((ncyc + nn[d] + 1) / (nn[d] + 2)));
  endtask

  initial begin
    logic [127:0] v, e;
    for (int i = 0; i < 256; i++) sbox_t[i] = fwd_sbox(8'(i));
    for (int i = 0; i < 256; i++) isbox_t[sbox_t[i]] = 8'(i);

    RST = 1'b0; enable = 1'b0; bytes = '0;
    repeat (2) @(negedge CLK);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst out%0d", d), out_w[d], '0);
      chk($sformatf("rst done%0d", d), b2w(done_w[d]), '0);
      chk($sformatf("rst busy%0d", d), b2w(busy_w[d]), '0);
      chk($sformatf("rst xfree%0d", d), b2w($isunknown(out_w[d])), '0);
    end
    RST = 1'b1;

    run_block(V1, V1_X, "vec1");
    run_block({8'h00, 8'h63, 8'hed, 8'h16, 8'h7c, {11{8'h00}}},
              {8'h52, 8'h00, 8'h53, 8'hff, 8'h01, {11{8'h52}}}, "spot");
    for (int b = 0; b < 16; b++) begin
      for (int k = 0; k < 16; k++) begin
        v[8*k +: 8] = sbox_t[16*b + k];
        e[8*k +: 8] = 8'(16*b + k);
      end
      run_block(v, e, $sformatf("exh%0d", b));
    end
    for (int r = 0; r < 4; r++) begin
      v = rnd128();
      run_block(v, model(v), $sformatf("rnd%0d", r));
    end

    for (int t = 0; t < 40; t++) hist[t] = rnd128();
    run_stream(40, "stream");

    hist[0] = {16{8'h63}};
    for (int t = 1; t < 8; t++) hist[t] = {16{8'h16}};
    run_stream(8, "b2b");

    // Abort LANES=4 when cnt=2 (third busy cycle); nothing must complete afterwards.
    @(negedge CLK);
    bytes = V1; enable = 1'b1;
    @(negedge CLK);
    enable = 1'b0;
    repeat (2) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("abort out%0d", d), out_w[d], '0);
      chk($sformatf("abort done%0d", d), b2w(done_w[d]), '0);
      chk($sformatf("abort busy%0d", d), b2w(busy_w[d]), '0);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk($sformatf("abort quiet%0d", c), b2w(done_w[0] | done_w[1] | done_w[2]), '0);
    end
    RST = 1'b1;
    run_block(V1, V1_X, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
